pipe_alu: RTL and testbench
===========================

PIPE_ALU -- requirements
Module: pipe_alu

Interface
REQ-001 Parameter: W, default 16, datapath width in bits; legal range 4..64.
REQ-002 Parameter: SW, default $clog2(W), width of the shift/rotate amount field taken from B[SW-1:0].
REQ-003 Clock and reset are one clock and one reset; reset is synchronous and active-high.
REQ-004 Port: clk  input  1  rising-edge clock for all state.
REQ-005 Port: rst  input  1  synchronous active-high reset.
REQ-006 Port: in_valid  input  1  operand/opcode present.
REQ-007 Port: in_ready  output  1  block can accept an operation this cycle.
REQ-008 Port: A, B  input  W each  operands; op  input  4  opcode.
REQ-009 Port: out_valid  output  1  result registers hold an unconsumed result.
REQ-010 Port: out_ready  input  1  consumer takes result this cycle.
REQ-011 Port: Y  output  W; carry, overflow, zero, negative  output  1 each; all registered.
REQ-012 Port: busy  output  1  iterative divide in progress.

Function
REQ-013 Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 XNOR, 6 SLL, 7 SRL, 8 ROL, 9 ROR, A GT, B EQ, C MUL, D DIV, E CLR, F NOP.
REQ-014 Transfer in: in_valid && in_ready at a rising edge; transfer out: out_valid && out_ready at a rising edge.
REQ-015 in_ready = !rst && !busy && (!out_valid || out_ready); back-to-back single-cycle ops sustain one per clock.
REQ-016 States: IDLE (no result held), HOLD (out_valid=1), DIV (busy=1, iterating).
REQ-017 IDLE/HOLD: accepted non-DIV op -> HOLD, result registered at that edge (latency 1); accepted DIV -> DIV.
REQ-018 HOLD with out_ready and no accept -> IDLE; HOLD with out_valid=0 never occurs.
REQ-019 DIV: unsigned restoring divider, one quotient bit per cycle; accept at edge N -> out_valid=1 after edge N+W, state HOLD.
REQ-020 During DIV: in_ready=0, out_valid=0, A/B/op inputs ignored; operands captured at accept.
REQ-021 Unaccepted results remain stable (Y and all flags) until consumed.
REQ-022 ADD: Y=(A+B) mod 2^W, carry=bit W of sum, overflow=signed overflow.
REQ-023 SUB: Y=(A-B) mod 2^W, carry=borrow (A<B unsigned), overflow=signed overflow.
REQ-024 AND/OR/XOR/XNOR bitwise; CLR Y=0; NOP Y=A.
REQ-025 SLL/SRL: shift A by s=B[SW-1:0], zero fill; carry=last bit shifted out, 0 when s=0.
REQ-026 ROL/ROR: rotate A by s=B[SW-1:0]; carry=0; s=0 returns A.
REQ-027 GT: Y=1 if A>B unsigned else 0; EQ: Y=1 if A==B else 0.
REQ-028 MUL: Y=low W bits of A*B; overflow=1 when high W bits nonzero.
REQ-029 DIV: Y=floor(A/B); B=0 -> Y=0, overflow=1, still W-cycle latency.
REQ-030 All ops: zero=(Y==0), negative=Y[W-1]; carry/overflow=0 where not defined above.

Reset
REQ-031 rst sampled high: state IDLE, Y=0, all flags 0, out_valid=0, busy=0; in_ready=0 while rst high, 1 the cycle after.
REQ-032 rst during DIV or HOLD aborts/discards the operation; no out_valid pulse follows.
REQ-033 rst has priority over any simultaneous accept or consume.

Verification
REQ-034 W=8, ADD A=FF B=01, out_ready=1 -> next cycle out_valid=1, Y=00, carry=1, zero=1.
REQ-035 W=8, SUB 7F-FF -> Y=80, carry=1, overflow=1, negative=1.
REQ-036 W=8, DIV 14/04 -> busy 8 cycles, in_ready=0, then Y=05; DIV 07/00 -> Y=00, overflow=1.
REQ-037 W=8, ROL A=81 s=3 -> Y=0C; SLL A=81 s=1 -> Y=02, carry=1.
REQ-038 Back-to-back ADD stream with out_ready held 0 for 3 cycles -> Y stable, in_ready=0, no op lost or duplicated.
REQ-039 rst asserted 3 cycles into a DIV -> outputs zero, busy=0, no result emitted; next ADD completes normally.

Source files
------------

// File: rtl/pipe_alu.sv
// Pipelined ALU with a valid/ready handshake on both sides and an iterative
// restoring divider; single-cycle ops complete in one clock, DIV takes W clocks.
module pipe_alu #(
  parameter int W  = 16,
  parameter int SW = $clog2(W)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic [3:0]   op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] Y,
  output logic         carry,
  output logic         overflow,
  output logic         zero,
  output logic         negative,
  output logic         busy
);

  localparam int CW = $clog2(W);

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_XNOR = 4'h5;
  localparam logic [3:0] OP_SLL  = 4'h6;
  localparam logic [3:0] OP_SRL  = 4'h7;
  localparam logic [3:0] OP_ROL  = 4'h8;
  localparam logic [3:0] OP_ROR  = 4'h9;
  localparam logic [3:0] OP_GT   = 4'hA;
  localparam logic [3:0] OP_EQ   = 4'hB;
  localparam logic [3:0] OP_MUL  = 4'hC;
  localparam logic [3:0] OP_DIV  = 4'hD;
  localparam logic [3:0] OP_CLR  = 4'hE;

  typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_DIV} state_e;

  state_e         r_state, w_nextState;
  logic [W-1:0]   r_y;
  logic           r_carry, r_ovf, r_zero, r_neg;
  logic [W-1:0]   r_quotient, r_rem, r_divisor;
  logic [CW-1:0]  r_cnt;

  logic           w_accept, w_isDiv, w_divDone, w_divZero, w_qBit;
  logic [SW-1:0]  w_shamt;
  logic [31:0]    w_rotAmt;
  logic [W:0]     w_sum, w_diffAB, w_sll, w_srl, w_remShift, w_diff;
  logic [2*W-1:0] w_prod;
  logic [W-1:0]   w_remNext, w_quoNext, w_divY;
  logic [W-1:0]   w_aluY;
  logic           w_aluC, w_aluV;

  assign in_ready  = !rst && (r_state != ST_DIV) && ((r_state != ST_HOLD) || out_ready);
  assign w_accept  = in_valid && in_ready;
  assign w_isDiv   = (op == OP_DIV);
  assign w_divDone = (r_cnt == CW'(W - 1));

  assign out_valid = (r_state == ST_HOLD);
  assign busy      = (r_state == ST_DIV);
  assign Y         = r_y;
  assign carry     = r_carry;
  assign overflow  = r_ovf;
  assign zero      = r_zero;
  assign negative  = r_neg;

  // Shifts are one bit wider so the last bit shifted out lands in a fixed position.
  assign w_shamt  = B[SW-1:0];
  assign w_rotAmt = 32'(w_shamt) % 32'(W);
  assign w_sum    = {1'b0, A} + {1'b0, B};
  assign w_diffAB = {1'b0, A} - {1'b0, B};
  assign w_sll    = {1'b0, A} << w_shamt;
  assign w_srl    = {A, 1'b0} >> w_shamt;
  assign w_prod   = {{W{1'b0}}, A} * {{W{1'b0}}, B};

  always_comb begin
    w_aluY = '0;
    w_aluC = 1'b0;
    w_aluV = 1'b0;
    case (op)
      OP_ADD: begin
        w_aluY = w_sum[W-1:0];
        w_aluC = w_sum[W];
        w_aluV = (A[W-1] == B[W-1]) && (w_sum[W-1] != A[W-1]);
      end
      OP_SUB: begin
        w_aluY = w_diffAB[W-1:0];
        w_aluC = w_diffAB[W];
        w_aluV = (A[W-1] != B[W-1]) && (w_diffAB[W-1] != A[W-1]);
      end
      OP_AND:  w_aluY = A & B;
      OP_OR:   w_aluY = A | B;
      OP_XOR:  w_aluY = A ^ B;
      OP_XNOR: w_aluY = ~(A ^ B);
      OP_SLL: begin
        w_aluY = w_sll[W-1:0];
        w_aluC = w_sll[W];
      end
      OP_SRL: begin
        w_aluY = w_srl[W:1];
        w_aluC = w_srl[0];
      end
      OP_ROL:  w_aluY = (A << w_rotAmt) | (A >> (32'(W) - w_rotAmt));
      OP_ROR:  w_aluY = (A >> w_rotAmt) | (A << (32'(W) - w_rotAmt));
      OP_GT:   w_aluY = {{(W-1){1'b0}}, (A > B)};
      OP_EQ:   w_aluY = {{(W-1){1'b0}}, (A == B)};
      OP_MUL: begin
        w_aluY = w_prod[W-1:0];
        w_aluV = |w_prod[2*W-1:W];
      end
      OP_CLR:  w_aluY = '0;
      default: w_aluY = A;
    endcase
  end

  // One restoring step: the dividend drains out of the quotient register MSB first.
  assign w_remShift = {r_rem, r_quotient[W-1]};
  assign w_diff     = w_remShift - {1'b0, r_divisor};
  assign w_qBit     = ~w_diff[W];
  assign w_remNext  = w_qBit ? w_diff[W-1:0] : w_remShift[W-1:0];
  assign w_quoNext  = {r_quotient[W-2:0], w_qBit};
  assign w_divZero  = (r_divisor == '0);
  assign w_divY     = w_divZero ? '0 : w_quoNext;

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE, ST_HOLD: begin
        if (w_accept)
          w_nextState = w_isDiv ? ST_DIV : ST_HOLD;
        else if ((r_state == ST_HOLD) && !out_ready)
          w_nextState = ST_HOLD;
        else
          w_nextState = ST_IDLE;
      end
      ST_DIV:  if (w_divDone) w_nextState = ST_HOLD;
      default: w_nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_nextState;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_y        <= '0;
      r_carry    <= 1'b0;
      r_ovf      <= 1'b0;
      r_zero     <= 1'b0;
      r_neg      <= 1'b0;
      r_quotient <= '0;
      r_rem      <= '0;
      r_divisor  <= '0;
      r_cnt      <= '0;
    end else if (w_accept) begin
      if (w_isDiv) begin
        r_quotient <= A;
        r_divisor  <= B;
        r_rem      <= '0;
        r_cnt      <= '0;
      end else begin
        r_y     <= w_aluY;
        r_carry <= w_aluC;
        r_ovf   <= w_aluV;
        r_zero  <= (w_aluY == '0);
        r_neg   <= w_aluY[W-1];
      end
    end else if (r_state == ST_DIV) begin
      r_quotient <= w_quoNext;
      r_rem      <= w_remNext;
      r_cnt      <= r_cnt + CW'(1);
      if (w_divDone) begin
        r_y     <= w_divY;
        r_carry <= 1'b0;
        r_ovf   <= w_divZero;
        r_zero  <= (w_divY == '0);
        r_neg   <= w_divY[W-1];
      end
    end
  end

endmodule

// File: tb/tb_pipe_alu.sv
// Scoreboard bench for pipe_alu at W=8: expected results are queued when an
// operation is accepted and compared when the result is consumed.
module tb_pipe_alu;

  localparam int W  = 8;
  localparam int SW = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] A, B, Y;
  logic [3:0]   op;
  logic         carry, overflow, zero, negative, busy;

  typedef struct packed {
    logic [W-1:0] y;
    logic         c;
    logic         v;
    logic         z;
    logic         n;
  } Exp_t;

  Exp_t expQ[$];
  Exp_t mExp;
  Exp_t stallExp;
  int   nChecks = 0;
  int   nPass   = 0;
  int   waits;

  always #5 clk = ~clk;

  pipe_alu #(.W(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .op(op),
    .out_valid(out_valid), .out_ready(out_ready),
    .Y(Y), .carry(carry), .overflow(overflow), .zero(zero), .negative(negative),
    .busy(busy)
  );

  // Independent reference written bit-serially where the RTL uses wide shifts.
  function automatic Exp_t model(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    Exp_t e;
    int ia, ib, sa, sb, r, s;
    e  = '0;
    ia = int'(a);
    ib = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    s  = int'(b[SW-1:0]);
    case (o)
      4'h0: begin r = ia + ib; e.y = r[W-1:0]; e.c = (r > 255); e.v = (sa + sb > 127) || (sa + sb < -128); end
      4'h1: begin r = ia - ib; e.y = r[W-1:0]; e.c = (ia < ib); e.v = (sa - sb > 127) || (sa - sb < -128); end
      4'h2: e.y = a & b;
      4'h3: e.y = a | b;
      4'h4: e.y = a ^ b;
      4'h5: e.y = ~(a ^ b);
      4'h6: begin e.y = a; for (int k = 0; k < s; k++) begin e.c = e.y[W-1]; e.y = {e.y[W-2:0], 1'b0}; end end
      4'h7: begin e.y = a; for (int k = 0; k < s; k++) begin e.c = e.y[0]; e.y = {1'b0, e.y[W-1:1]}; end end
      4'h8: begin e.y = a; for (int k = 0; k < s; k++) e.y = {e.y[W-2:0], e.y[W-1]}; end
      4'h9: begin e.y = a; for (int k = 0; k < s; k++) e.y = {e.y[0], e.y[W-1:1]}; end
      4'hA: e.y = (ia > ib) ? 8'd1 : 8'd0;
      4'hB: e.y = (ia == ib) ? 8'd1 : 8'd0;
      4'hC: begin r = ia * ib; e.y = r[W-1:0]; e.v = (r > 255); end
      4'hD: begin
        if (ib == 0) begin e.y = '0; e.v = 1'b1; end
        else begin r = ia / ib; e.y = r[W-1:0]; end
      end
      4'hE: e.y = '0;
      default: e.y = a;
    endcase
    e.z = (e.y == '0);
    e.n = e.y[W-1];
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs === exp) nPass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  // Presents one op and waits for its accept edge; leaves in_valid high so calls chain back-to-back.
  task automatic applyStimulus(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b, output int nWait);
    bit done;
    done     = 1'b0;
    nWait    = 0;
    op       = o;
    A        = a;
    B        = b;
    in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        expQ.push_back(model(o, a, b));
        done = 1'b1;
      end else if (nWait >= 60) begin
        checkOutput("accept_timeout", 32'd0, 32'd1);
        done = 1'b1;
      end else begin
        nWait++;
      end
      @(posedge clk); #1;
      if (!done) out_ready = 1'b1;
    end
  endtask

  task automatic idleCycles(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic divLatency(input logic [W-1:0] a, input logic [W-1:0] b);
    out_ready = 1'b1;
    applyStimulus(4'hD, a, b, waits);
    for (int i = 0; i < W; i++) begin
      op = 4'($urandom_range(0, 15));
      A  = W'($urandom);
      B  = W'($urandom);
      @(negedge clk);
      checkOutput("div_busy", 32'(busy), 32'd1);
      checkOutput("div_in_ready", 32'(in_ready), 32'd0);
      checkOutput("div_out_valid", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("div_done_valid", 32'(out_valid), 32'd1);
    checkOutput("div_done_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b1;
    op        = 4'h0;
    A         = 8'h01;
    B         = 8'h01;
    out_ready = 1'b1;

    fork
      forever begin
        @(negedge clk);
        if (!rst && out_valid && out_ready) begin
          if (expQ.size() == 0) begin
            checkOutput("unexpected_result", 32'd1, 32'd0);
          end else begin
            mExp = expQ.pop_front();
            checkOutput("result", 32'({Y, carry, overflow, zero, negative}), 32'(mExp));
          end
        end
      end
    join_none

    // Reset held with a pending op: nothing may be accepted.
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd0);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_outputs", 32'({Y, carry, overflow, zero, negative}), 32'd0);
    @(posedge clk); #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_reset", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // Latency-1 ADD with carry out and zero result.
    applyStimulus(4'h0, 8'hFF, 8'h01, waits);
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("add_latency1", 32'(out_valid), 32'd1);
    @(posedge clk); #1;

    // Directed single-cycle ops issued back-to-back.
    applyStimulus(4'h1, 8'h7F, 8'hFF, waits);
    applyStimulus(4'h8, 8'h81, 8'h03, waits);
    applyStimulus(4'h6, 8'h81, 8'h01, waits);
    applyStimulus(4'h7, 8'h81, 8'h01, waits);
    applyStimulus(4'h9, 8'h81, 8'h03, waits);
    applyStimulus(4'h6, 8'h5A, 8'h00, waits);
    applyStimulus(4'h0, 8'h7F, 8'h01, waits);
    applyStimulus(4'hC, 8'h10, 8'h20, waits);
    applyStimulus(4'hA, 8'h80, 8'h7F, waits);
    applyStimulus(4'hB, 8'h33, 8'h33, waits);
    applyStimulus(4'h5, 8'hF0, 8'hCC, waits);
    applyStimulus(4'hE, 8'hAB, 8'hCD, waits);
    applyStimulus(4'hF, 8'h9C, 8'h11, waits);
    idleCycles(2);

    divLatency(8'h14, 8'h04);
    divLatency(8'h07, 8'h00);
    divLatency(8'hFF, 8'h01);

    // Consumer stalls for three cycles while the next ADD waits.
    out_ready = 1'b1;
    applyStimulus(4'h0, 8'h10, 8'h20, waits);
    out_ready = 1'b0;
    op        = 4'h0;
    A         = 8'h30;
    B         = 8'h40;
    stallExp  = model(4'h0, 8'h10, 8'h20);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
      checkOutput("stall_out_valid", 32'(out_valid), 32'd1);
      checkOutput("stall_result", 32'({Y, carry, overflow, zero, negative}), 32'(stallExp));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    applyStimulus(4'h0, 8'h30, 8'h40, waits);
    checkOutput("stream_resume_waits", 32'(waits), 32'd0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'h0, W'($urandom), W'($urandom), waits);
      checkOutput("b2b_waits", 32'(waits), 32'd0);
    end
    idleCycles(3);
    checkOutput("stream_drained", 32'(expQ.size()), 32'd0);

    // Reset three cycles into a divide discards it.
    applyStimulus(4'hD, 8'h64, 8'h07, waits);
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    expQ.delete();
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_out_valid", 32'(out_valid), 32'd0);
    checkOutput("abort_outputs", 32'({Y, carry, overflow, zero, negative}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < W + 2; i++) begin
      @(negedge clk);
      checkOutput("abort_no_result", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
    end
    applyStimulus(4'h0, 8'h05, 8'h06, waits);
    idleCycles(2);
    checkOutput("abort_recovered", 32'(expQ.size()), 32'd0);

    // Random ops with a randomly stalling consumer.
    for (int i = 0; i < 60; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      applyStimulus(4'($urandom_range(0, 15)), W'($urandom), W'($urandom), waits);
      if ($urandom_range(0, 3) == 0) begin
        out_ready = ($urandom_range(0, 1) != 0);
        idleCycles(1);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    idleCycles(W + 5);
    checkOutput("random_drained", 32'(expQ.size()), 32'd0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
